// File: rtl/ball_pkg.sv
// Shared types and per-ball geometry helpers for the ball sprite engine.
package ball_pkg;

  localparam int unsigned DEF_CNT_W = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int unsigned ball_size(input int unsigned idx, input int unsigned step);
    return (idx + 1) * step;
  endfunction

  function automatic int unsigned ball_delta(input int unsigned idx, input int unsigned base,
                                             input int unsigned step);
    return base + idx * step;
  endfunction

  function automatic int unsigned ball_start(input int unsigned idx, input int unsigned step,
                                             input int unsigned res);
    return (idx * step) % res;
  endfunction

endpackage

// File: rtl/ball_motion.sv
// One bouncing ball: position/direction state, edge bounce on the update strobe, and
// the combinational coverage test for the current pixel.
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned X_RES   = 640,
  parameter int unsigned Y_RES   = 480,
  parameter int unsigned SIZE    = 40,
  parameter int unsigned DELTA   = 1,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             i_step,
  input  logic             i_flip,
  input  logic [CNT_W-1:0] i_hcnt,
  input  logic [CNT_W-1:0] i_vcnt,
  output logic             o_hit
);

  if (SIZE >= X_RES || SIZE >= Y_RES) begin : g_bad_size
    $error("ball_motion: ball size %0d does not fit the active area", SIZE);
  end
  if (SIZE < X_RES && SIZE < Y_RES && (DELTA >= X_RES - SIZE || DELTA >= Y_RES - SIZE))
  begin : g_bad_delta
    $error("ball_motion: speed %0d too large for ball size %0d", DELTA, SIZE);
  end

  localparam logic [CNT_W:0]   L_XMAX = (CNT_W+1)'(X_RES - SIZE);
  localparam logic [CNT_W:0]   L_YMAX = (CNT_W+1)'(Y_RES - SIZE);
  localparam logic [CNT_W:0]   L_D    = (CNT_W+1)'(DELTA);
  localparam logic [CNT_W:0]   L_W    = (CNT_W+1)'(SIZE);
  localparam logic [CNT_W-1:0] L_SX   = CNT_W'(START_X);
  localparam logic [CNT_W-1:0] L_SY   = CNT_W'(START_Y);

  logic [CNT_W-1:0] r_x, r_y;
  logic             r_dir_x, r_dir_y;
  logic [CNT_W-1:0] w_nx, w_ny;
  logic             w_ndx, w_ndy;

  // Returns {next_dir, next_pos}; the sum is kept one bit wider so it cannot wrap.
  function automatic logic [CNT_W:0] axis_step(input logic [CNT_W-1:0] pos, input logic dir,
                                               input logic [CNT_W:0] lim);
    logic [CNT_W:0] nxt;
    nxt = {1'b0, pos} + L_D;
    if (!dir) begin
      if (nxt >= lim) return {1'b1, lim[CNT_W-1:0]};
      return {1'b0, nxt[CNT_W-1:0]};
    end
    if ({1'b0, pos} <= L_D) return '0;
    return {1'b1, pos - L_D[CNT_W-1:0]};
  endfunction

  always_comb begin
    {w_ndx, w_nx} = axis_step(r_x, r_dir_x ^ i_flip, L_XMAX);
    {w_ndy, w_ny} = axis_step(r_y, r_dir_y ^ i_flip, L_YMAX);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_x     <= L_SX;
      r_y     <= L_SY;
      r_dir_x <= 1'b0;
      r_dir_y <= 1'b0;
    end else if (i_step) begin
      r_x     <= w_nx;
      r_y     <= w_ny;
      r_dir_x <= w_ndx;
      r_dir_y <= w_ndy;
    end
  end

  assign o_hit = ({1'b0, i_hcnt} >= {1'b0, r_x}) && ({1'b0, i_hcnt} < ({1'b0, r_x} + L_W)) &&
                 ({1'b0, i_vcnt} >= {1'b0, r_y}) && ({1'b0, i_vcnt} < ({1'b0, r_y} + L_W));

endmodule

// File: rtl/ball_sprite_engine.sv
// Multi-ball sprite compositor with a two-stage pixel pipeline. Define BALL_COLLISION_EN
// to build the ball-to-ball collision response; otherwise o_collide is tied to zero.
module ball_sprite_engine
  import ball_pkg::*;
#(
  parameter int unsigned         N_BALLS     = 4,
  parameter int unsigned         X_RES       = 640,
  parameter int unsigned         Y_RES       = 480,
  parameter int unsigned         CNT_W       = DEF_CNT_W,
  parameter int unsigned         SIZE_STEP   = 40,
  parameter int unsigned         DELTA_BASE  = 1,
  parameter int unsigned         DELTA_STEP  = 8,
  parameter int unsigned         START_STEP  = 10,
  parameter logic [24*N_BALLS-1:0] BALL_COLORS =
      {24'hFFFFFF, 24'h00FF00, 24'h0000FF, 24'hFF0000}
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   i_hcnt,
  input  logic [CNT_W-1:0]   i_vcnt,
  input  logic               i_blank,
  input  logic [23:0]        i_bg_rgb,
  input  logic               i_freeze,
  output logic [23:0]        o_rgb,
  output logic               o_blank,
  output logic [N_BALLS-1:0] o_hit,
  output logic               o_frame_tick,
  output logic [N_BALLS-1:0] o_collide
);

  if (N_BALLS < 1 || N_BALLS > 8) begin : g_bad_n
    $error("ball_sprite_engine: N_BALLS must be 1..8");
  end

  localparam logic [CNT_W-1:0] L_UPD_LINE = CNT_W'(Y_RES);

  logic               w_update, w_step;
  logic [N_BALLS-1:0] w_hit, w_flip;
  logic [N_BALLS-1:0] r_hit_s1, r_hit;
  rgb_t               r_bg_s1, r_rgb, w_mix;
  logic               r_blank_s1, r_blank, r_frame_tick;

  // First line of vertical blanking, column 0: happens once per frame.
  assign w_update = (i_hcnt == '0) && (i_vcnt == L_UPD_LINE);
  assign w_step   = w_update && !i_freeze;

  for (genvar g = 0; g < N_BALLS; g++) begin : g_ball
    ball_motion #(
      .CNT_W  (CNT_W),
      .X_RES  (X_RES),
      .Y_RES  (Y_RES),
      .SIZE   (ball_size(g, SIZE_STEP)),
      .DELTA  (ball_delta(g, DELTA_BASE, DELTA_STEP)),
      .START_X(ball_start(g, START_STEP, X_RES)),
      .START_Y(ball_start(g, START_STEP, Y_RES))
    ) u_motion (
      .pclk  (pclk),
      .reset (reset),
      .i_step(w_step),
      .i_flip(w_flip[g]),
      .i_hcnt(i_hcnt),
      .i_vcnt(i_vcnt),
      .o_hit (w_hit[g])
    );
  end

`ifdef BALL_COLLISION_EN
  logic [N_BALLS-1:0] r_sticky, r_collide, w_act_hit;
  logic               w_multi;

  assign w_act_hit = i_blank ? '0 : w_hit;
  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign w_multi   = |(w_act_hit & (w_act_hit - 1'b1));
  assign w_flip    = r_sticky;
  assign o_collide = r_collide;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_sticky  <= '0;
      r_collide <= '0;
    end else if (w_update) begin
      r_collide <= r_sticky;
      r_sticky  <= '0;
    end else if (w_multi) begin
      r_sticky  <= r_sticky | w_act_hit;
    end
  end
`else
  assign w_flip    = '0;
  assign o_collide = '0;
`endif

  always_comb begin
    w_mix = r_bg_s1;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (r_hit_s1[i]) w_mix = BALL_COLORS[24*i +: 24];
    end
    if (r_blank_s1) w_mix = '0;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_hit_s1     <= '0;
      r_bg_s1      <= '0;
      r_blank_s1   <= 1'b1;
      r_hit        <= '0;
      r_rgb        <= '0;
      r_blank      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_hit_s1     <= i_blank ? '0 : w_hit;
      r_bg_s1      <= i_bg_rgb;
      r_blank_s1   <= i_blank;
      r_hit        <= r_hit_s1;
      r_rgb        <= w_mix;
      r_blank      <= r_blank_s1;
      r_frame_tick <= w_update;
    end
  end

  assign o_rgb        = r_rgb;
  assign o_blank      = r_blank;
  assign o_hit        = r_hit;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_ball_sprite_engine.sv
// Directed bench for ball_sprite_engine with two balls (40px @1, 80px @9).
module tb_ball_sprite_engine;

`ifdef BALL_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] hcnt = 11'd700;
  logic [10:0] vcnt = 11'd500;
  logic        blank = 1'b1;
  logic [23:0] bg = 24'h101010;
  logic        freeze = 1'b0;
  logic [23:0] rgb;
  logic        oblank;
  logic [1:0]  hit;
  logic        tick;
  logic [1:0]  collide;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  logic [1:0]  p_hit;
  logic [23:0] p_rgb;

  ball_sprite_engine #(
    .N_BALLS    (2),
    .BALL_COLORS({24'h0000FF, 24'hFF0000})
  ) dut (
    .pclk        (pclk),
    .reset       (reset),
    .i_hcnt      (hcnt),
    .i_vcnt      (vcnt),
    .i_blank     (blank),
    .i_bg_rgb    (bg),
    .i_freeze    (freeze),
    .o_rgb       (rgb),
    .o_blank     (oblank),
    .o_hit       (hit),
    .o_frame_tick(tick),
    .o_collide   (collide)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (tick) tick_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge pclk); #1;
    reset = 1'b1; blank = 1'b1; hcnt = 11'd700; vcnt = 11'd500;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;
  endtask

  task automatic probe(input int h, input int v);
    @(posedge pclk); #1;
    hcnt = 11'(h); vcnt = 11'(v); blank = 1'b0;
    @(posedge pclk);
    @(posedge pclk); #1;
    p_hit = hit; p_rgb = rgb;
    hcnt = 11'd700; vcnt = 11'd500; blank = 1'b1;
  endtask

  task automatic do_update();
    @(posedge pclk); #1;
    hcnt = 11'd0; vcnt = 11'd480; blank = 1'b1;
    @(posedge pclk); #1;
    hcnt = 11'd700; vcnt = 11'd500;
  endtask

  task automatic test_reset();
    // Reset asserted during active video must flush the pipeline on the next edge.
    @(posedge pclk); #1;
    hcnt = 11'd5; vcnt = 11'd5; blank = 1'b0;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b1;
    @(posedge pclk); #1;
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL rst_flush_rgb: got %h want %h", rgb, 24'h0); end
    checks++; if (oblank !== 1'b1) begin errors++; $display("FAIL rst_flush_blank: got %b want 1", oblank); end
    blank = 1'b1; hcnt = 11'd700; vcnt = 11'd500;
    repeat (2) @(posedge pclk);
    #1;
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL rst_hit: got %b want 00", hit); end
    checks++; if (collide !== 2'b00) begin errors++; $display("FAIL rst_collide: got %b want 00", collide); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", tick); end
    reset = 1'b0;
    probe(0, 0);
    checks++; if (p_hit !== 2'b01) begin errors++; $display("FAIL rst_b0_origin: got %b want 01", p_hit); end
    probe(10, 9);
    checks++; if (p_hit !== 2'b01) begin errors++; $display("FAIL rst_b1_above: got %b want 01", p_hit); end
    probe(10, 50);
    checks++; if (p_hit !== 2'b10) begin errors++; $display("FAIL rst_b1_left: got %b want 10", p_hit); end
    probe(9, 50);
    checks++; if (p_hit !== 2'b00) begin errors++; $display("FAIL rst_b1_xm1: got %b want 00", p_hit); end
    probe(89, 89);
    checks++; if (p_hit !== 2'b10) begin errors++; $display("FAIL rst_b1_far: got %b want 10", p_hit); end
    probe(90, 89);
    checks++; if (p_hit !== 2'b00) begin errors++; $display("FAIL rst_b1_past: got %b want 00", p_hit); end
  endtask

  task automatic test_latency();
    do_reset();
    bg = 24'h101010;
    @(posedge pclk); #1;
    hcnt = 11'd5; vcnt = 11'd5; blank = 1'b0;
    @(posedge pclk); #1;
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL lat_early: got %h want %h", rgb, 24'h0); end
    @(posedge pclk); #1;
    checks++; if (rgb !== 24'hFF0000) begin errors++; $display("FAIL lat_rgb: got %h want %h", rgb, 24'hFF0000); end
    checks++; if (hit !== 2'b01) begin errors++; $display("FAIL lat_hit: got %b want 01", hit); end
    checks++; if (oblank !== 1'b0) begin errors++; $display("FAIL lat_blank: got %b want 0", oblank); end
    probe(40, 5);
    checks++; if (p_rgb !== 24'h101010) begin errors++; $display("FAIL lat_bg: got %h want %h", p_rgb, 24'h101010); end
    checks++; if (p_hit !== 2'b00) begin errors++; $display("FAIL lat_bg_hit: got %b want 00", p_hit); end
    @(posedge pclk); #1;
    hcnt = 11'd5; vcnt = 11'd5; blank = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL lat_blank_rgb: got %h want %h", rgb, 24'h0); end
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL lat_blank_hit: got %b want 00", hit); end
    checks++; if (oblank !== 1'b1) begin errors++; $display("FAIL lat_blank_out: got %b want 1", oblank); end
    hcnt = 11'd700; vcnt = 11'd500;
  endtask

  task automatic test_priority();
    do_reset();
    probe(20, 20);
    checks++; if (p_rgb !== 24'hFF0000) begin errors++; $display("FAIL prio_rgb: got %h want %h", p_rgb, 24'hFF0000); end
    checks++; if (p_hit !== 2'b11) begin errors++; $display("FAIL prio_hit: got %b want 11", p_hit); end
  endtask

  task automatic test_bounce();
    int t0;
    do_reset();
    t0 = tick_cnt;
    for (int k = 0; k < 600; k++) do_update();
    @(posedge pclk); #1;
    checks++; if (tick_cnt - t0 !== 600) begin errors++; $display("FAIL bounce_ticks: got %0d want 600", tick_cnt - t0); end
    // ball0 now at (600,280); ball1 sits at x=254..333, away from ball0
    probe(600, 280);
    checks++; if (p_hit[0] !== 1'b1) begin errors++; $display("FAIL bounce_x600_in: got %b want 1", p_hit[0]); end
    probe(599, 280);
    checks++; if (p_hit[0] !== 1'b0) begin errors++; $display("FAIL bounce_x600_out: got %b want 0", p_hit[0]); end
    @(posedge pclk); #1;
    hcnt = 11'd0; vcnt = 11'd480;
    @(posedge pclk); #1;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL tick_high: got %b want 1", tick); end
    hcnt = 11'd700; vcnt = 11'd500;
    @(posedge pclk); #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_once: got %b want 0", tick); end
    probe(599, 279);
    checks++; if (p_hit[0] !== 1'b1) begin errors++; $display("FAIL bounce_x599_in: got %b want 1", p_hit[0]); end
    probe(598, 279);
    checks++; if (p_hit[0] !== 1'b0) begin errors++; $display("FAIL bounce_x599_out: got %b want 0", p_hit[0]); end
    probe(638, 279);
    checks++; if (p_hit[0] !== 1'b1) begin errors++; $display("FAIL bounce_right_in: got %b want 1", p_hit[0]); end
    probe(639, 279);
    checks++; if (p_hit[0] !== 1'b0) begin errors++; $display("FAIL bounce_right_out: got %b want 0", p_hit[0]); end
  endtask

  task automatic test_freeze();
    int t0;
    do_reset();
    t0 = tick_cnt;
    freeze = 1'b1;
    repeat (3) do_update();
    freeze = 1'b0;
    @(posedge pclk); #1;
    checks++; if (tick_cnt - t0 !== 3) begin errors++; $display("FAIL frz_ticks: got %0d want 3", tick_cnt - t0); end
    probe(0, 0);
    checks++; if (p_hit !== 2'b01) begin errors++; $display("FAIL frz_b0: got %b want 01", p_hit); end
    probe(10, 10);
    checks++; if (p_hit !== 2'b11) begin errors++; $display("FAIL frz_b1: got %b want 11", p_hit); end
    // Freeze pulsed away from the update event must not matter.
    @(posedge pclk); #1 freeze = 1'b1;
    @(posedge pclk); #1 freeze = 1'b0;
    do_update();
    probe(0, 0);
    checks++; if (p_hit !== 2'b00) begin errors++; $display("FAIL rel_origin: got %b want 00", p_hit); end
    probe(1, 1);
    checks++; if (p_hit !== 2'b01) begin errors++; $display("FAIL rel_b0: got %b want 01", p_hit); end
    probe(18, 19);
    checks++; if (p_hit !== 2'b01) begin errors++; $display("FAIL rel_b1_xm1: got %b want 01", p_hit); end
    probe(19, 19);
    checks++; if (p_hit !== 2'b11) begin errors++; $display("FAIL rel_b1: got %b want 11", p_hit); end
  endtask

  task automatic test_collision();
    logic [1:0] exp_c;
    exp_c = COLL ? 2'b11 : 2'b00;
    do_reset();
    probe(20, 20);
    do_update();
    checks++; if (collide !== exp_c) begin errors++; $display("FAIL coll_flag: got %b want %b", collide, exp_c); end
    probe(40, 1);
    checks++; if (p_hit !== (COLL ? 2'b10 : 2'b01)) begin errors++; $display("FAIL coll_pos_a: got %b want %b", p_hit, COLL ? 2'b10 : 2'b01); end
    probe(0, 0);
    checks++; if (p_hit !== (COLL ? 2'b01 : 2'b00)) begin errors++; $display("FAIL coll_pos_b: got %b want %b", p_hit, COLL ? 2'b01 : 2'b00); end
    probe(81, 1);
    checks++; if (p_hit !== 2'b00) begin errors++; $display("FAIL coll_pos_c: got %b want 00", p_hit); end
    checks++; if (collide !== exp_c) begin errors++; $display("FAIL coll_hold: got %b want %b", collide, exp_c); end
    do_update();
    checks++; if (collide !== 2'b00) begin errors++; $display("FAIL coll_clear: got %b want 00", collide); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_priority();
    test_bounce();
    test_freeze();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
